// File: rtl/ic_decerr_mo_if.sv
// AXI channel bundle for the default (unmapped-address) slave; the slave modport faces the DUT.
interface ic_decerr_mo_if #(
  parameter int ID_BITS   = 4,
  parameter int DATA_BITS = 64,
  parameter int LEN_BITS  = 4,
  parameter int USER_BITS = 1
);
  logic                 AWIDOK;
  logic                 ARIDOK;

  logic [ID_BITS-1:0]   AWID;
  logic [LEN_BITS-1:0]  AWLEN;
  logic                 AWVALID;
  logic                 AWREADY;

  logic [DATA_BITS-1:0] WDATA;
  logic                 WLAST;
  logic                 WVALID;
  logic                 WREADY;

  logic [ID_BITS-1:0]   BID;
  logic [1:0]           BRESP;
  logic [USER_BITS-1:0] BUSER;
  logic                 BVALID;
  logic                 BREADY;

  logic [ID_BITS-1:0]   ARID;
  logic [LEN_BITS-1:0]  ARLEN;
  logic                 ARVALID;
  logic                 ARREADY;

  logic [ID_BITS-1:0]   RID;
  logic [DATA_BITS-1:0] RDATA;
  logic [1:0]           RRESP;
  logic                 RLAST;
  logic [USER_BITS-1:0] RUSER;
  logic                 RVALID;
  logic                 RREADY;

  modport slave (
    input  AWIDOK, ARIDOK,
    input  AWID, AWLEN, AWVALID, output AWREADY,
    input  WDATA, WLAST, WVALID, output WREADY,
    output BID, BRESP, BUSER, BVALID, input BREADY,
    input  ARID, ARLEN, ARVALID, output ARREADY,
    output RID, RDATA, RRESP, RLAST, RUSER, RVALID, input RREADY
  );

  modport master (
    output AWIDOK, ARIDOK,
    output AWID, AWLEN, AWVALID, input AWREADY,
    output WDATA, WLAST, WVALID, input WREADY,
    input  BID, BRESP, BUSER, BVALID, output BREADY,
    output ARID, ARLEN, ARVALID, input ARREADY,
    input  RID, RDATA, RRESP, RLAST, RUSER, RVALID, output RREADY
  );
endinterface

// File: rtl/ic_decerr_mo.sv
// Default AXI slave: answers every write with one B and every read with ARLEN+1 zero beats,
// DECERR when the ID was accepted upstream, SLVERR otherwise. Write and read sides are independent.
module ic_decerr_mo #(
  parameter int ID_BITS   = 4,
  parameter int DATA_BITS = 64,
  parameter int LEN_BITS  = 4,
  parameter int USER_BITS = 1,
  parameter int AW_DEPTH  = 4,
  parameter int AR_DEPTH  = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  ic_decerr_mo_if.slave  bus
);
  localparam int AW_PW = (AW_DEPTH > 1) ? $clog2(AW_DEPTH) : 1;
  localparam int AR_PW = (AR_DEPTH > 1) ? $clog2(AR_DEPTH) : 1;
  localparam int AW_CW = $clog2(AW_DEPTH + 1);
  localparam int AR_CW = $clog2(AR_DEPTH + 1);
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [ID_BITS-1:0] id;
    logic               ok;
  } aw_entry_t;

  typedef struct packed {
    logic [ID_BITS-1:0]  id;
    logic [LEN_BITS-1:0] len;
    logic                ok;
  } ar_entry_t;

  typedef enum logic {R_IDLE, R_BURST} r_state_e;

  logic                r_rdy_en;
  logic                w_unused;

  aw_entry_t           r_aw_mem [AW_DEPTH];
  logic [AW_PW-1:0]    r_aw_wptr, r_aw_rptr;
  logic [AW_CW-1:0]    r_aw_cnt, r_wl_cnt;
  aw_entry_t           w_aw_head;
  logic                w_aw_push, w_wl_push, w_b_pop;
  logic                r_bvalid;
  logic [ID_BITS-1:0]  r_bid;
  logic [1:0]          r_bresp;

  ar_entry_t           r_ar_mem [AR_DEPTH];
  logic [AR_PW-1:0]    r_ar_wptr, r_ar_rptr;
  logic [AR_CW-1:0]    r_ar_cnt;
  ar_entry_t           w_ar_head;
  logic                w_ar_push, w_ar_nempty;
  r_state_e            r_state, w_r_next;
  logic                w_r_load, w_r_dec;
  logic [ID_BITS-1:0]  r_rid;
  logic [1:0]          r_rresp;
  logic [LEN_BITS-1:0] r_beat;

  // Readies stay low until the first clock edge after reset release.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rdy_en <= 1'b0;
    else          r_rdy_en <= 1'b1;
  end

  assign w_unused = ^{bus.AWLEN, bus.WDATA};

  // ---------------- write side ----------------
  assign bus.AWREADY = r_rdy_en & (r_aw_cnt != AW_CW'(AW_DEPTH));
  assign bus.WREADY  = r_rdy_en & (r_wl_cnt != AW_CW'(AW_DEPTH));
  assign w_aw_push   = bus.AWVALID & bus.AWREADY;
  assign w_wl_push   = bus.WVALID & bus.WREADY & bus.WLAST;
  assign w_aw_head   = r_aw_mem[r_aw_rptr];
  assign w_b_pop     = (~r_bvalid | bus.BREADY) & (r_aw_cnt != '0) & (r_wl_cnt != '0);

  // NOTE: queue storage has no reset; the occupancy counts gate every read, so stale entries never escape.
  always_ff @(posedge clk) begin
    if (w_aw_push) r_aw_mem[r_aw_wptr] <= '{id: bus.AWID, ok: bus.AWIDOK};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_aw_wptr <= '0;
      r_aw_rptr <= '0;
      r_aw_cnt  <= '0;
      r_wl_cnt  <= '0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= 2'b00;
    end else begin
      if (w_aw_push)
        r_aw_wptr <= (r_aw_wptr == AW_PW'(AW_DEPTH - 1)) ? '0 : r_aw_wptr + AW_PW'(1);
      if (w_b_pop)
        r_aw_rptr <= (r_aw_rptr == AW_PW'(AW_DEPTH - 1)) ? '0 : r_aw_rptr + AW_PW'(1);
      case ({w_aw_push, w_b_pop})
        2'b10:   r_aw_cnt <= r_aw_cnt + AW_CW'(1);
        2'b01:   r_aw_cnt <= r_aw_cnt - AW_CW'(1);
        default: ;
      endcase
      case ({w_wl_push, w_b_pop})
        2'b10:   r_wl_cnt <= r_wl_cnt + AW_CW'(1);
        2'b01:   r_wl_cnt <= r_wl_cnt - AW_CW'(1);
        default: ;
      endcase
      if (w_b_pop) begin
        r_bvalid <= 1'b1;
        r_bid    <= w_aw_head.id;
        r_bresp  <= w_aw_head.ok ? RESP_DECERR : RESP_SLVERR;
      end else if (bus.BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  assign bus.BVALID = r_bvalid;
  assign bus.BID    = r_bid;
  assign bus.BRESP  = r_bresp;
  assign bus.BUSER  = {USER_BITS{1'b0}};

  // ---------------- read side ----------------
  assign bus.ARREADY = r_rdy_en & (r_ar_cnt != AR_CW'(AR_DEPTH));
  assign w_ar_push   = bus.ARVALID & bus.ARREADY;
  assign w_ar_nempty = (r_ar_cnt != '0);
  assign w_ar_head   = r_ar_mem[r_ar_rptr];

  always_ff @(posedge clk) begin
    if (w_ar_push) r_ar_mem[r_ar_wptr] <= '{id: bus.ARID, len: bus.ARLEN, ok: bus.ARIDOK};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ar_wptr <= '0;
      r_ar_rptr <= '0;
      r_ar_cnt  <= '0;
    end else begin
      if (w_ar_push)
        r_ar_wptr <= (r_ar_wptr == AR_PW'(AR_DEPTH - 1)) ? '0 : r_ar_wptr + AR_PW'(1);
      if (w_r_load)
        r_ar_rptr <= (r_ar_rptr == AR_PW'(AR_DEPTH - 1)) ? '0 : r_ar_rptr + AR_PW'(1);
      case ({w_ar_push, w_r_load})
        2'b10:   r_ar_cnt <= r_ar_cnt + AR_CW'(1);
        2'b01:   r_ar_cnt <= r_ar_cnt - AR_CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= R_IDLE;
    else          r_state <= w_r_next;
  end

  // A last-beat handshake with a queued command reloads on the same edge, giving zero-bubble bursts.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_r_next = r_state;
    w_r_load = 1'b0;
    w_r_dec  = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (w_ar_nempty) begin
          w_r_load = 1'b1;
          w_r_next = R_BURST;
        end
      end
      R_BURST: begin
        if (bus.RREADY) begin
          if (r_beat != '0)     w_r_dec  = 1'b1;
          else if (w_ar_nempty) w_r_load = 1'b1;
          else                  w_r_next = R_IDLE;
        end
      end
      default: w_r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rid   <= '0;
      r_rresp <= 2'b00;
      r_beat  <= '0;
    end else if (w_r_load) begin
      r_rid   <= w_ar_head.id;
      r_rresp <= w_ar_head.ok ? RESP_DECERR : RESP_SLVERR;
      r_beat  <= w_ar_head.len;
    end else if (w_r_dec) begin
      r_beat  <= r_beat - LEN_BITS'(1);
    end
  end

  assign bus.RVALID = (r_state == R_BURST);
  assign bus.RLAST  = (r_state == R_BURST) & (r_beat == '0);
  assign bus.RID    = r_rid;
  assign bus.RRESP  = r_rresp;
  assign bus.RDATA  = {DATA_BITS{1'b0}};
  assign bus.RUSER  = {USER_BITS{1'b0}};
endmodule
